// File: rtl/tt6502_bus_sequencer.sv
// tt6502_bus_sequencer
// Splits each 6502 bus cycle into address-low, address-high and data phases
// on the Tiny Tapeout pins, then pulses cpu_ce for one clock so the core
// advances.
// Optional feature macro: TT6502_BUS_WAIT_EN enables ext_wait stretching,
// the wait counter and the bus_timeout flag. Without it every bus cycle is
// exactly 4 clocks.
module tt6502_bus_sequencer #(
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ena,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_dout,
   input  logic        cpu_we,
   input  logic        cpu_sync,
   output logic [7:0]  cpu_din,
   output logic        cpu_ce,
   input  logic        ext_wait,
   output logic [7:0]  uo_out,
   input  logic [7:0]  uio_in,
   output logic [7:0]  uio_out,
   output logic [7:0]  uio_oe,
   output logic        bus_timeout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_AL,
      S_AH,
      S_DATA,
      S_STEP
   } state_t;

   state_t state_q, state_d;
   logic   data_done;

`ifdef TT6502_BUS_WAIT_EN
   localparam logic [7:0] WAIT_MAX_B = 8'(WAIT_MAX);

   logic [7:0] wait_cnt;
   logic       data_force;

   // Forced completion: still waiting but the stretch budget is used up.
   assign data_force = ext_wait && (wait_cnt == WAIT_MAX_B);
   assign data_done  = !ext_wait || data_force;

   // Wait counter: cleared while in AH so it starts at 0 on DATA entry,
   // counts each stretched DATA clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wait_cnt <= 8'h00;
      else if (state_q == S_AH)
         wait_cnt <= 8'h00;
      else if (state_q == S_DATA && !data_done)
         wait_cnt <= wait_cnt + 8'h01;
   end

   // Sticky timeout flag, set on the forcing edge, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         bus_timeout <= 1'b0;
      else if (state_q == S_DATA && data_force)
         bus_timeout <= 1'b1;
   end
`else
   logic unused_wait_cfg;

   // Without stretching DATA always completes on its first edge.
   assign data_done       = 1'b1;
   assign bus_timeout     = 1'b0;
   assign unused_wait_cfg = ext_wait | (WAIT_MAX == 0);
`endif

   // State register; async reset drops the pins to idle immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // Read data capture on the completing DATA edge (forced or not).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cpu_din <= 8'h00;
      else if (state_q == S_DATA && data_done && !cpu_we)
         cpu_din <= uio_in;
   end

   // Next state and pin multiplexing; outputs decode straight from state.
   always_comb begin
      state_d = state_q;
      uo_out  = 8'h00;
      uio_out = 8'h00;
      uio_oe  = 8'h00;
      cpu_ce  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ena)
               state_d = S_AL;
         end
         S_AL: begin
            uo_out  = cpu_addr[7:0];
            uio_oe  = 8'hFF;
            uio_out = {5'b0, cpu_sync, cpu_we, 1'b0};
            state_d = S_AH;
         end
         S_AH: begin
            uo_out  = cpu_addr[15:8];
            uio_oe  = 8'hFF;
            uio_out = {5'b0, cpu_sync, cpu_we, 1'b1};
            state_d = S_DATA;
         end
         S_DATA: begin
            uo_out = cpu_addr[7:0];
            if (cpu_we) begin
               uio_oe  = 8'hFF;
               uio_out = cpu_dout;
            end
            if (data_done)
               state_d = S_STEP;
         end
         S_STEP: begin
            cpu_ce  = 1'b1;
            state_d = ena ? S_AL : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_tt6502_bus_sequencer.sv
// Directed bench for tt6502_bus_sequencer with hand-computed expectations.
// Built with WAIT_MAX=4; wait-dependent expectations follow TT6502_BUS_WAIT_EN.
module tb_tt6502_bus_sequencer;

`ifdef TT6502_BUS_WAIT_EN
   localparam bit WAIT_ON = 1'b1;
`else
   localparam bit WAIT_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ena;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_dout;
   logic        cpu_we;
   logic        cpu_sync;
   logic [7:0]  cpu_din;
   logic        cpu_ce;
   logic        ext_wait;
   logic [7:0]  uo_out;
   logic [7:0]  uio_in;
   logic [7:0]  uio_out;
   logic [7:0]  uio_oe;
   logic        bus_timeout;

   int checks   = 0;
   int failures = 0;
   int len;

   tt6502_bus_sequencer #(.WAIT_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena),
      .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we),
      .cpu_sync(cpu_sync), .cpu_din(cpu_din), .cpu_ce(cpu_ce),
      .ext_wait(ext_wait), .uo_out(uo_out), .uio_in(uio_in),
      .uio_out(uio_out), .uio_oe(uio_oe), .bus_timeout(bus_timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pins(input string tag, input logic [7:0] uo, input logic [7:0] uo_d,
                       input logic [7:0] oe, input logic ce);
      check({tag, "_uo"},  uo_out,  uo);
      check({tag, "_uio"}, uio_out, uo_d);
      check({tag, "_oe"},  uio_oe,  oe);
      check({tag, "_ce"},  cpu_ce,  ce);
   endtask

   // From just before the AL edge: run one cycle, holding ext_wait for the
   // first 'hold' DATA edges. len = clocks from AL through STEP.
   task automatic run_cycle(input int hold, output int clocks);
      int n;
      n = 0;
      ext_wait = 1'b0;
      tick; tick; tick;
      check("cyc_data_ce", cpu_ce, 1'b0);
      do begin
         ext_wait = (n < hold);
         tick;
         n++;
      end while (!cpu_ce && n < 40);
      ext_wait = 1'b0;
      check("cyc_step_seen", cpu_ce, 1'b1);
      clocks = 3 + n;
   endtask

   initial begin
      rst_n = 1'b0; ena = 1'b1; ext_wait = 1'b0;
      cpu_addr = 16'hFFFC; cpu_dout = 8'h00; cpu_we = 1'b0; cpu_sync = 1'b0;
      uio_in = 8'h34;

      // Reset holds everything at 0 even with ena high.
      tick; tick;
      pins("rst", 8'h00, 8'h00, 8'h00, 1'b0);
      check("rst_din", cpu_din, 8'h00);
      check("rst_to", bus_timeout, 1'b0);
      rst_n = 1'b1;

      // Read from FFFC.
      tick; pins("rd_al", 8'hFC, 8'h00, 8'hFF, 1'b0);
      tick; pins("rd_ah", 8'hFF, 8'h01, 8'hFF, 1'b0);
      tick; pins("rd_data", 8'hFC, 8'h00, 8'h00, 1'b0);
      tick; pins("rd_step", 8'h00, 8'h00, 8'h00, 1'b1);
      check("rd_din", cpu_din, 8'h34);

      // Write A5 to 0200 as an opcode-fetch-flagged cycle; no idle gap.
      cpu_addr = 16'h0200; cpu_dout = 8'hA5; cpu_we = 1'b1; cpu_sync = 1'b1;
      uio_in = 8'h77;
      tick; pins("wr_al", 8'h00, 8'h06, 8'hFF, 1'b0);
      tick; pins("wr_ah", 8'h02, 8'h07, 8'hFF, 1'b0);
      tick; pins("wr_data", 8'h00, 8'hA5, 8'hFF, 1'b0);
      tick; pins("wr_step", 8'h00, 8'h00, 8'h00, 1'b1);
      check("wr_din_kept", cpu_din, 8'h34);

      // Read with 3 wait edges.
      cpu_addr = 16'h1234; cpu_we = 1'b0; cpu_sync = 1'b0; uio_in = 8'h5A;
      run_cycle(3, len);
      check("wait_len", len, WAIT_ON ? 7 : 4);
      check("wait_din", cpu_din, 8'h5A);
      check("wait_to", bus_timeout, 1'b0);

      // ext_wait stuck: forced after WAIT_MAX+1 DATA clocks, still captures.
      uio_in = 8'hC3;
      run_cycle(100, len);
      check("to_len", len, WAIT_ON ? 8 : 4);
      check("to_din", cpu_din, 8'hC3);
      check("to_flag", bus_timeout, WAIT_ON);

      // Following normal cycle: 4 clocks, flag stays sticky.
      uio_in = 8'h11;
      run_cycle(0, len);
      check("post_len", len, 4);
      check("post_to", bus_timeout, WAIT_ON);
      check("post_din", cpu_din, 8'h11);

      // Drop ena during AH: cycle completes, then park in IDLE.
      tick; pins("ena_al", 8'h34, 8'h00, 8'hFF, 1'b0);
      ena = 1'b0;
      tick; pins("ena_ah", 8'h12, 8'h01, 8'hFF, 1'b0);
      tick; tick;
      check("ena_step_ce", cpu_ce, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick;
         pins("ena_idle", 8'h00, 8'h00, 8'h00, 1'b0);
      end

      // Reset during a write DATA phase: pins drop asynchronously.
      ena = 1'b1; cpu_we = 1'b1; cpu_dout = 8'h5C;
      tick; tick; tick;
      pins("rdat_pre", 8'h34, 8'h5C, 8'hFF, 1'b0);
      #2 rst_n = 1'b0;
      #1 pins("rdat_async", 8'h00, 8'h00, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick;
         check("rdat_hold_ce", cpu_ce, 1'b0);
      end
      check("rdat_to", bus_timeout, 1'b0);
      check("rdat_din", cpu_din, 8'h00);
      ena = 1'b0;
      rst_n = 1'b1;
      tick; tick;
      pins("rdat_idle", 8'h00, 8'h00, 8'h00, 1'b0);
      ena = 1'b1;
      tick; pins("rdat_al", 8'h34, 8'h02, 8'hFF, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog so the bench always reaches a summary.
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/tt6502_bus_sequencer.md
# tt6502_bus_sequencer

Bus-cycle sequencer between the 6502 core and the Tiny Tapeout pin set. The core's 16-bit address and 8-bit data bus do not fit the 8 dedicated outputs plus 8 bidirectional pins, so this block splits every CPU bus cycle into address-low, address-high and data phases. It time-multiplexes `uo_out`/`uio`, owns `uio_oe`, and gates the core with a one-cycle clock enable once the data phase completes.

## Interface
- `WAIT_MAX`, default 15: maximum wait-stretch cycles per data phase before forced completion (range 1–255).
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `ena`  in  1  design selected; gates the start of new bus cycles.
- `cpu_addr`  in  16  core address, stable whenever `cpu_ce`=0.
- `cpu_dout`  in  8  core write data.
- `cpu_we`  in  1  core write strobe (1=write, 0=read).
- `cpu_sync`  in  1  core opcode-fetch flag.
- `cpu_din`  out  8  registered read data to the core.
- `cpu_ce`  out  1  core clock enable, one-cycle pulse per bus cycle.
- `ext_wait`  in  1  external wait request; from `ui_in[0]` at top level.
- `uo_out`  out  8  multiplexed address byte.
- `uio_in`  in  8  external read data.
- `uio_out`  out  8  status byte, or write data.
- `uio_oe`  out  8  bidirectional enables (1=drive).
- `bus_timeout`  out  1  sticky flag: a data phase was force-completed.

## Operation
- FSM states: IDLE, AL, AH, DATA, STEP.
- IDLE: all outputs 0. Go to AL when `ena`=1.
- AL:
  - `uo_out`=`cpu_addr[7:0]`, `uio_oe`=8'hFF.
  - `uio_out`={5'b0, `cpu_sync`, `cpu_we`, 1'b0}.
  - Next state AH.
- AH:
  - `uo_out`=`cpu_addr[15:8]`, `uio_oe`=8'hFF.
  - `uio_out`={5'b0, `cpu_sync`, `cpu_we`, 1'b1}.
  - Next state DATA.
- DATA, read (`cpu_we`=0):
  - `uo_out`=`cpu_addr[7:0]`, `uio_oe`=8'h00, `uio_out`=8'h00.
  - On the completing edge, `cpu_din`<=`uio_in`.
- DATA, write (`cpu_we`=1):
  - `uo_out`=`cpu_addr[7:0]`, `uio_oe`=8'hFF, `uio_out`=`cpu_dout`.
  - `cpu_din` unchanged.
- DATA completes on an edge where `ext_wait`=0, or where the wait counter equals `WAIT_MAX`. Next state STEP.
- STEP:
  - `cpu_ce`=1 for exactly this cycle; `uo_out`=8'h00, `uio_oe`=8'h00, `uio_out`=8'h00.
  - Core advances at the end of STEP.
  - Next state AL if `ena`=1, else IDLE.
- `ena` falling mid-cycle does not abort the cycle. The current cycle runs through STEP, then the FSM parks in IDLE.
- `cpu_ce` is driven only from STEP; no other state asserts it.

## Timing
- Reset (async assert, synchronous release): state IDLE, `cpu_ce`=0, `cpu_din`=8'h00, `bus_timeout`=0, wait counter 0, `uo_out`/`uio_out`/`uio_oe`=0.
- Minimum bus cycle is 4 clocks (AL, AH, DATA, STEP). Back-to-back cycles have no idle gap.
- Each DATA-phase edge with `ext_wait`=1 (counter < `WAIT_MAX`) adds one clock and increments the 8-bit wait counter.
- Counter clears on entry to DATA.
- Wait cap: if `ext_wait` is held, DATA lasts exactly `WAIT_MAX`+1 clocks. On the forcing edge:
  - `bus_timeout`<=1, sticky until reset.
  - For a read, `cpu_din` captures `uio_in` anyway.
- Reset asserted mid-cycle: immediate return to IDLE, `uio_oe`=0 the same instant (asynchronous), no `cpu_ce` pulse.
- `cpu_din` is valid from the STEP cycle until the next read completes.

## Configuration
- `TT6502_BUS_WAIT_EN` defined:
  - `ext_wait` and the wait counter are active; `WAIT_MAX` applies; `bus_timeout` is functional.
- Not defined:
  - `ext_wait` is ignored and DATA is always 1 clock; every bus cycle is exactly 4 clocks.
  - `bus_timeout` is tied 0 and no counter is instantiated.

## Test plan
- Reset: with `rst_n`=0 → all outputs 0. Release with `ena`=1 → AL on the next clock.
- Read, `cpu_addr`=16'hFFFC, `uio_in`=8'h34:
  - `uo_out` sequence 8'hFC, 8'hFF, 8'hFC, 8'h00.
  - `uio_out` during AL/AH = 8'h00, 8'h01.
  - `cpu_ce` high in clock 4; `cpu_din`=8'h34 in STEP.
- Write, `cpu_addr`=16'h0200, `cpu_dout`=8'hA5, `cpu_sync`=1:
  - AL/AH `uio_out`=8'h06/8'h07.
  - DATA `uio_oe`=8'hFF, `uio_out`=8'hA5.
  - `cpu_din` unchanged.
- Wait, macro on: `ext_wait`=1 for 3 DATA edges → DATA lasts 4 clocks, bus cycle 7 clocks, `bus_timeout`=0.
- Timeout, `WAIT_MAX`=4, `ext_wait` stuck 1:
  - DATA lasts 5 clocks, then STEP with `cpu_ce`=1.
  - `bus_timeout`=1 and stays 1 across later cycles.
- Drop `ena` during AH → cycle completes through STEP, FSM enters IDLE, no further `cpu_ce`. Assert `rst_n`=0 during DATA → `uio_oe`=0 immediately, no `cpu_ce`.
